// File: rtl/fp16_seg_display.sv
// Captures an FP16 word plus class flags and scans it in hex onto a 4-digit common-anode display.
// Optional NaN blink of the whole display: define FP16_SEG_NAN_BLINK_EN.
module fp16_seg_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_TICKS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [5:0]  class_in,
   input  logic        load,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [5:0]  class_led
);
   localparam int CW = $clog2(REFRESH_DIV);

   if (REFRESH_DIV < 2 || BLINK_TICKS < 1) begin : g_param_chk
      $error("fp16_seg_display: REFRESH_DIV must be >= 2 and BLINK_TICKS >= 1");
   end

   logic [15:0]   shadow;
   logic [CW-1:0] ref_cnt;
   logic [1:0]    idx;
   logic          adv;
   logic          blank;
   logic [3:0]    nib;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;

   assign adv = (ref_cnt == CW'(REFRESH_DIV - 1));

   // load only touches the captured word/flags; the scan keeps its phase
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow    <= '0;
         class_led <= '0;
         ref_cnt   <= '0;
         idx       <= '0;
      end else begin
         ref_cnt <= adv ? '0 : ref_cnt + CW'(1);
         if (adv)
            idx <= idx + 2'd1;
         if (load) begin
            shadow    <= value;
            class_led <= class_in;
         end
      end
   end

`ifdef FP16_SEG_NAN_BLINK_EN
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (adv) begin
         if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign blank = blink_phase & (class_led[5] | class_led[4]);
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      nib    = shadow[3:0];
      an_nxt = 4'b1110;
      case (idx)
         2'd0: begin nib = shadow[3:0];   an_nxt = 4'b1110; end
         2'd1: begin nib = shadow[7:4];   an_nxt = 4'b1101; end
         2'd2: begin nib = shadow[11:8];  an_nxt = 4'b1011; end
         2'd3: begin nib = shadow[15:12]; an_nxt = 4'b0111; end
         default: ;
      endcase
   end

   always_comb begin
      seg_nxt = 7'h7F;
      case (nib)
         4'h0: seg_nxt = 7'b1000000;
         4'h1: seg_nxt = 7'b1111001;
         4'h2: seg_nxt = 7'b0100100;
         4'h3: seg_nxt = 7'b0110000;
         4'h4: seg_nxt = 7'b0011001;
         4'h5: seg_nxt = 7'b0010010;
         4'h6: seg_nxt = 7'b0000010;
         4'h7: seg_nxt = 7'b1111000;
         4'h8: seg_nxt = 7'b0000000;
         4'h9: seg_nxt = 7'b0010000;
         4'hA: seg_nxt = 7'b0001000;
         4'hB: seg_nxt = 7'b0000011;
         4'hC: seg_nxt = 7'b1000110;
         4'hD: seg_nxt = 7'b0100001;
         4'hE: seg_nxt = 7'b0000110;
         4'hF: seg_nxt = 7'b0001110;
         default: ;
      endcase
   end

   // sign rides on the leftmost digit's decimal point
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= 7'h7F;
         dp  <= 1'b1;
         an  <= 4'hF;
      end else begin
         seg <= seg_nxt;
         an  <= blank ? 4'hF : an_nxt;
         dp  <= blank | ~((idx == 2'd3) & shadow[15]);
      end
   end

endmodule

// File: tb/tb_fp16_seg_display.sv
// Bench for fp16_seg_display: directed vector table, hand sequences, then random traffic vs a scan model.
module tb_fp16_seg_display;
   localparam int RD = 4;
   localparam int BT = 2;

   logic        clk = 1'b0;
   logic        rst, load;
   logic [15:0] value;
   logic [5:0]  class_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [5:0]  class_led;

   fp16_seg_display #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
      .clk(clk), .rst(rst), .value(value), .class_in(class_in), .load(load),
      .seg(seg), .dp(dp), .an(an), .class_led(class_led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, l;
      logic [15:0] v;
      logic [5:0]  c;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic [5:0]  cls;
   } vec_t;

   logic [6:0] hexseg [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int passed = 0;
   int total  = 0;

   // model: edges since reset release, digit advances since last load/reset, captured word/flags
   int          k;
   int          advs;
   logic [15:0] sh_m;
   logic [5:0]  cl_m;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic tick(input logic r, input logic l, input logic [15:0] v, input logic [5:0] c);
      int   di;
      logic blank;
      rst = r; load = l; value = v; class_in = c;
      @(posedge clk);
      #1;
      if (r) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         sh_m = '0; cl_m = '0; k = 0; advs = 0;
      end else begin
         di    = (k / RD) % 4;
         blank = 1'b0;
`ifdef FP16_SEG_NAN_BLINK_EN
         blank = (cl_m[5] | cl_m[4]) && ((advs / BT) % 2 == 1);
`endif
         e_seg = hexseg[sh_m[di*4 +: 4]];
         e_an  = blank ? 4'hF : ~(4'b0001 << di);
         e_dp  = blank || !(di == 3 && sh_m[15]);
         if (l) begin
            sh_m = v; cl_m = c; advs = 0;
         end else if (k % RD == RD - 1) begin
            advs++;
         end
         k++;
`ifndef FP16_SEG_NAN_BLINK_EN
         check("an_lit", 32'(an == 4'hF), 32'd0);
`endif
      end
      check("model", {14'd0, an, seg, dp, class_led}, {14'd0, e_an, e_seg, e_dp, cl_m});
   endtask

   function automatic vec_t mk(logic r, logic l, logic [15:0] v, logic [5:0] c,
                               logic [3:0] a, logic [6:0] s, logic d, logic [5:0] cl);
      vec_t x;
      x.r = r; x.l = l; x.v = v; x.c = c; x.an = a; x.seg = s; x.dp = d; x.cls = cl;
      return x;
   endfunction

   initial begin
      vec_t tbl[$];
      int   seen;
      rst = 1'b1; load = 1'b0; value = '0; class_in = '0;

      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 16'h0, 6'h0, 4'hF, 7'h7F, 1, 6'h0));
      tbl.push_back(mk(0, 1, 16'h3C00, 6'b000001, 4'b1110, 7'b1000000, 1, 6'b000001));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 16'h0, 6'h0, 4'b1110, 7'b1000000, 1, 6'b000001));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 16'h0, 6'h0, 4'b1101, 7'b1000000, 1, 6'b000001));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 16'h0, 6'h0, 4'b1011, 7'b1000110, 1, 6'b000001));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 16'h0, 6'h0, 4'b0111, 7'b0110000, 1, 6'b000001));
      tbl.push_back(mk(0, 0, 16'h0, 6'h0, 4'b1110, 7'b1000000, 1, 6'b000001));

      foreach (tbl[i]) begin
         tick(tbl[i].r, tbl[i].l, tbl[i].v, tbl[i].c);
         check("vec", {14'd0, an, seg, dp, class_led},
               {14'd0, tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].cls});
      end

      // negative value: sign on the leftmost decimal point only
      tick(0, 1, 16'hBC00, 6'b000001);
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         tick(0, 0, 16'h0, 6'h0);
         if (an == 4'b0111) begin
            seen++;
            check("bc00_dp_on", {31'd0, dp}, 32'd0);
            check("bc00_seg_b", {25'd0, seg}, {25'd0, 7'b0000011});
         end else begin
            check("bc00_dp_off", {31'd0, dp}, 32'd1);
         end
      end
      check("bc00_seen", seen, 32'd4);

      // load in the middle of digit 2
      for (int i = 0; i < 16 && (k % 16) != 9; i++) tick(0, 0, 16'h0, 6'h0);
      check("mid_align", k % 16, 32'd9);
      tick(0, 1, 16'h1234, 6'b000001);
      check("mid_old", {21'd0, an, seg}, {21'd0, 4'b1011, 7'b1000110});
      tick(0, 0, 16'h0, 6'h0);
      check("mid_new", {21'd0, an, seg}, {21'd0, 4'b1011, 7'b0100100});
      tick(0, 0, 16'h0, 6'h0);
      tick(0, 0, 16'h0, 6'h0);
      check("mid_next", {20'd0, an, seg, dp}, {20'd0, 4'b0111, 7'b1111001, 1'b1});

      // reset wins over load
      tick(1, 1, 16'hFFFF, 6'h3F);
      check("rst_load", {14'd0, an, seg, dp, class_led}, {14'd0, 4'hF, 7'h7F, 1'b1, 6'h0});
      tick(0, 0, 16'h0, 6'h0);
      check("rst_load_after", {15'd0, an, seg, class_led}, {15'd0, 4'b1110, 7'b1000000, 6'h0});

      // quiet NaN held for several blink periods
      tick(0, 1, 16'h7E00, 6'b010000);
      for (int i = 0; i < 40; i++) tick(0, 0, 16'h0, 6'h0);

      // random traffic
      for (int i = 0; i < 400; i++)
         tick($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
              16'($urandom), 6'($urandom));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
